// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: two writeback sources (A = ALU, B = load unit) each feed a
// DEPTH-entry FIFO; one FIFO head per cycle is granted onto the registered write port.
// busy_mask flags registers with a write still queued or on the port.
// Optional build macro RFARB_FIXED_PRIO_EN: source A always wins ties (no round-robin state).
module rf_write_arbiter #(
  parameter int unsigned N     = 32,
  parameter int unsigned Bits  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [$clog2(N)-1:0] a_ptr,
  input  logic [Bits-1:0]      a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [$clog2(N)-1:0] b_ptr,
  input  logic [Bits-1:0]      b_data,
  output logic                 wr_en,
  output logic [$clog2(N)-1:0] ptr_wr,
  output logic [Bits-1:0]      data_wr,
  output logic [N-1:0]         busy_mask
);

  localparam int unsigned PW = $clog2(N);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Index 0 is source A, index 1 is source B. Entry 0 of each FIFO is its head.
  logic [PW-1:0]   ptr_q  [2][DEPTH];
  logic [PW-1:0]   ptr_d  [2][DEPTH];
  logic [Bits-1:0] data_q [2][DEPTH];
  logic [Bits-1:0] data_d [2][DEPTH];
  logic [CW-1:0]   cnt_q  [2];
  logic [CW-1:0]   cnt_d  [2];

  logic [PW-1:0]   in_ptr  [2];
  logic [Bits-1:0] in_data [2];
  logic [1:0]      in_valid, ready, push, head_vld, grant;

  logic [PW-1:0]   head_ptr;
  logic [Bits-1:0] head_data;
  logic            wr_en_q;
  logic [PW-1:0]   ptr_wr_q;
  logic [Bits-1:0] data_wr_q;

  assign in_valid   = {b_valid, a_valid};
  assign in_ptr[0]  = a_ptr;
  assign in_ptr[1]  = b_ptr;
  assign in_data[0] = a_data;
  assign in_data[1] = b_data;

  // Ready uses the pre-pop count, so a full FIFO never accepts even while being popped.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      ready[s]    = !rst && (cnt_q[s] < CW'(DEPTH));
      head_vld[s] = (cnt_q[s] != '0);
    end
  end

  assign push    = in_valid & ready;
  assign a_ready = ready[0];
  assign b_ready = ready[1];

`ifdef RFARB_FIXED_PRIO_EN
  // Fixed priority: B drains only when FIFO A is empty.
  always_comb begin
    grant[0] = head_vld[0];
    grant[1] = head_vld[1] && !head_vld[0];
  end
`else
  logic last_b_q, last_b_d;  // 1: B held the most recent grant

  // Round-robin: on a tie the source that did not win last time is granted.
  always_comb begin
    grant[0] = head_vld[0] && (!head_vld[1] || last_b_q);
    grant[1] = head_vld[1] && !grant[0];
    last_b_d = last_b_q;
    if (grant[0]) begin
      last_b_d = 1'b0;
    end else if (grant[1]) begin
      last_b_d = 1'b1;
    end
  end

  // Last-grant register; resets to B so A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`endif

  // FIFO next state: pop shifts toward the head, push lands just past the surviving entries.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      ptr_d[s]  = ptr_q[s];
      data_d[s] = data_q[s];
      cnt_d[s]  = cnt_q[s];
      if (grant[s]) begin
        for (int i = 0; i + 1 < int'(DEPTH); i++) begin
          ptr_d[s][i]  = ptr_q[s][i+1];
          data_d[s][i] = data_q[s][i+1];
        end
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push[s] && (i == int'(cnt_q[s]) - (grant[s] ? 1 : 0))) begin
          ptr_d[s][i]  = in_ptr[s];
          data_d[s][i] = in_data[s];
        end
      end
      case ({push[s], grant[s]})
        2'b10:   cnt_d[s] = cnt_q[s] + CW'(1);
        2'b01:   cnt_d[s] = cnt_q[s] - CW'(1);
        default: cnt_d[s] = cnt_q[s];
      endcase
    end
  end

  // FIFO occupancy; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage; contents beyond the count are don't-care, so no reset is needed.
  always_ff @(posedge clk) begin
    ptr_q  <= ptr_d;
    data_q <= data_d;
  end

  // Select the granted head for the output stage.
  always_comb begin
    head_ptr  = grant[1] ? ptr_q[1][0]  : ptr_q[0][0];
    head_data = grant[1] ? data_q[1][0] : data_q[0][0];
  end

  // Registered write port; x0 entries use the slot but never assert wr_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      ptr_wr_q  <= '0;
      data_wr_q <= '0;
    end else if (|grant) begin
      wr_en_q   <= (head_ptr != '0);
      ptr_wr_q  <= head_ptr;
      data_wr_q <= head_data;
    end else begin
      wr_en_q <= 1'b0;
    end
  end

  assign wr_en   = wr_en_q;
  assign ptr_wr  = ptr_wr_q;
  assign data_wr = data_wr_q;

  // Busy mask: decode of every valid queued pointer plus the live write on the port.
  always_comb begin
    busy_mask = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (i < int'(cnt_q[s])) begin
          busy_mask[ptr_q[s][i]] = 1'b1;
        end
      end
    end
    if (wr_en_q) begin
      busy_mask[ptr_wr_q] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected port writes are queued as stimulus is
// driven and popped by a negedge monitor whenever wr_en is seen high.
module tb_rf_write_arbiter;

  localparam int N     = 32;
  localparam int Bits  = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  ptr;
    logic [31:0] data;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_valid, a_ready, b_valid, b_ready;
  logic [4:0]      a_ptr, b_ptr, ptr_wr;
  logic [31:0]     a_data, b_data, data_wr;
  logic            wr_en;
  logic [N-1:0]    busy_mask;

  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  wr_t  exp_q[$];
  wr_t  a_src[$];
  wr_t  b_src[$];
  int   wr_cyc[$];
  logic a_rdy_hist[$];
  logic b_rdy_hist[$];
  int   t0;
  bit   done;

  rf_write_arbiter #(.N(N), .Bits(Bits), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_ptr     (a_ptr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_ptr     (b_ptr),
    .b_data    (b_data),
    .wr_en     (wr_en),
    .ptr_wr    (ptr_wr),
    .data_wr   (data_wr),
    .busy_mask (busy_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic wr_t mk(input logic [4:0] p, input logic [31:0] d);
    wr_t r;
    r.ptr  = p;
    r.data = d;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    tick();
    exp_q.delete();
    rst = 1'b0;
    #1;
  endtask

  // Drive both source lists, holding each request until it is accepted.
  task automatic streams(input int max_cyc, output bit all_done);
    int ia = 0;
    int ib = 0;
    a_rdy_hist.delete();
    b_rdy_hist.delete();
    for (int c = 0; c < max_cyc && (ia < a_src.size() || ib < b_src.size()); c++) begin
      a_valid = (ia < a_src.size());
      b_valid = (ib < b_src.size());
      if (a_valid) {a_ptr, a_data} = a_src[ia];
      if (b_valid) {b_ptr, b_data} = b_src[ib];
      #1;
      a_rdy_hist.push_back(a_ready);
      b_rdy_hist.push_back(b_ready);
      if (a_valid && a_ready) ia++;
      if (b_valid && b_ready) ib++;
      tick();
    end
    a_valid  = 1'b0;
    b_valid  = 1'b0;
    all_done = (ia == a_src.size()) && (ib == b_src.size());
  endtask

  // Scoreboard monitor: every observed write must match the oldest expected one.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      vectors++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed write ptr %0d data %0h, expected none",
               ptr_wr, data_wr);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_write", 64'({ptr_wr, data_wr}), 64'(e));
      end
    end
  end

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_ptr = '0; b_ptr = '0; a_data = '0; b_data = '0;

    // Reset state
    tick();
    tick();
    chk("rst_a_ready", 64'(a_ready), 64'(0));
    chk("rst_b_ready", 64'(b_ready), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_ptr_wr", 64'(ptr_wr), 64'(0));
    chk("rst_data_wr", 64'(data_wr), 64'(0));
    chk("rst_busy", 64'(busy_mask), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_a_ready", 64'(a_ready), 64'(1));
    chk("post_rst_b_ready", 64'(b_ready), 64'(1));

    // Single write: two-cycle latency, busy window t+1..t+2
    a_valid = 1'b1; a_ptr = 5'd5; a_data = 32'hDEADBEEF;
    exp_q.push_back(mk(5'd5, 32'hDEADBEEF));
    tick();
    a_valid = 1'b0;
    chk("s1_wr_en_t1", 64'(wr_en), 64'(0));
    chk("s1_busy_t1", 64'(busy_mask), 64'(32'h20));
    tick();
    chk("s1_wr_en_t2", 64'(wr_en), 64'(1));
    chk("s1_ptr_t2", 64'(ptr_wr), 64'(5));
    chk("s1_data_t2", 64'(data_wr), 64'(32'hDEADBEEF));
    chk("s1_busy_t2", 64'(busy_mask), 64'(32'h20));
    tick();
    chk("s1_wr_en_t3", 64'(wr_en), 64'(0));
    chk("s1_busy_t3", 64'(busy_mask), 64'(0));
    tick();
    chk("s1_drained", 64'(exp_q.size()), 64'(0));

    // Both sources stream: interleaved order (A-first under fixed priority), no bubbles
    do_reset();
    a_src.delete(); b_src.delete(); wr_cyc.delete();
    for (int i = 1; i <= 3; i++) begin
      a_src.push_back(mk(5'(i), 32'hA000_0000 + i));
      b_src.push_back(mk(5'(10 + i), 32'hB000_0000 + 10 + i));
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(a_src[i]);
`ifndef RFARB_FIXED_PRIO_EN
      exp_q.push_back(b_src[i]);
`endif
    end
`ifdef RFARB_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) exp_q.push_back(b_src[i]);
`endif
    t0 = cyc;
    streams(40, done);
    chk("s2_accept_all", 64'(done), 64'(1));
    chk("s2_b_ready_c0", 64'(b_rdy_hist.size() > 0 ? b_rdy_hist[0] : 1'bx), 64'(1));
    chk("s2_b_full_c2", 64'(b_rdy_hist.size() > 2 ? b_rdy_hist[2] : 1'bx), 64'(0));
`ifdef RFARB_FIXED_PRIO_EN
    chk("s2_a_ready_c3", 64'(a_rdy_hist.size() > 3 ? a_rdy_hist[3] : 1'bx), 64'(1));
`else
    chk("s2_a_full_pop_c3", 64'(a_rdy_hist.size() > 3 ? a_rdy_hist[3] : 1'bx), 64'(0));
`endif
    for (int i = 0; i < 8; i++) tick();
    chk("s2_nwrites", 64'(wr_cyc.size()), 64'(6));
    chk("s2_first_lat", 64'(wr_cyc.size() == 6 ? wr_cyc[0] - t0 : -1), 64'(2));
    chk("s2_no_bubble", 64'(wr_cyc.size() == 6 ? wr_cyc[5] - wr_cyc[0] : -1), 64'(5));
    chk("s2_drained", 64'(exp_q.size()), 64'(0));

    // x0 entry consumes a slot without writing; a following write still lands
    do_reset();
    a_valid = 1'b1; a_ptr = 5'd0; a_data = 32'h1234;
    tick();
    chk("x0_busy_t1", 64'(busy_mask), 64'(0));
    a_ptr = 5'd7; a_data = 32'h77;
    exp_q.push_back(mk(5'd7, 32'h77));
    tick();
    a_valid = 1'b0;
    chk("x0_wr_en_t2", 64'(wr_en), 64'(0));
    chk("x0_busy_t2", 64'(busy_mask), 64'(32'h80));
    tick();
    chk("x0_wr_en_t3", 64'(wr_en), 64'(1));
    chk("x0_ptr_t3", 64'(ptr_wr), 64'(7));
    tick();
    chk("x0_wr_en_t4", 64'(wr_en), 64'(0));
    chk("x0_busy_t4", 64'(busy_mask), 64'(0));
    chk("x0_drained", 64'(exp_q.size()), 64'(0));

    // Fill both FIFOs, reset mid-stream: nothing stale may reach the port afterwards
    do_reset();
    a_src.delete(); b_src.delete();
    for (int i = 0; i < 4; i++) begin
      a_src.push_back(mk(5'(21 + i), 32'hC000_0000 + i));
      b_src.push_back(mk(5'(25 + i), 32'hD000_0000 + i));
    end
`ifdef RFARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(a_src[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(b_src[i]);
`else
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(a_src[i]);
      exp_q.push_back(b_src[i]);
    end
`endif
    streams(4, done);
    rst = 1'b1;
    #1;
    chk("mid_rst_a_ready", 64'(a_ready), 64'(0));
    chk("mid_rst_b_ready", 64'(b_ready), 64'(0));
    tick();
    chk("mid_rst_written", 64'(exp_q.size()), 64'(5));
    exp_q.delete();
    chk("mid_rst_wr_en", 64'(wr_en), 64'(0));
    chk("mid_rst_busy", 64'(busy_mask), 64'(0));
    rst = 1'b0;
    #1;
    chk("after_rst_a_ready", 64'(a_ready), 64'(1));
    chk("after_rst_b_ready", 64'(b_ready), 64'(1));
    for (int i = 0; i < 6; i++) tick();
    chk("after_rst_busy", 64'(busy_mask), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
